// File: rtl/pipe_add.sv
// pipe_add: WIDTH-bit add/subtract split into STAGES registered carry segments.
// Define PIPE_ADD_OVF_EN to enable signed-overflow tracking; otherwise overflow is 0.
module pipe_add #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    input  logic             ci,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SEG = WIDTH / STAGES;

    logic             advance;
    logic [WIDTH-1:0] bcond;
    logic             ccond;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign bcond    = r2 ^ {WIDTH{sub}};
    assign ccond    = ci ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // b_in holds only the not-yet-consumed upper slices of B'
        localparam int BI = WIDTH - k * SEG;

        logic [WIDTH-1:0] x_in;
        logic [WIDTH-1:0] x_d;
        logic [BI-1:0]    b_in;
        logic             c_in;
        logic             v_in;
        logic [SEG:0]     sum;

        logic [WIDTH-1:0] x_q;
        logic             c_q;
        logic             v_q;

        if (k == 0) begin : g_in
            assign x_in = r1;
            assign b_in = bcond;
            assign c_in = ccond;
            assign v_in = in_valid;
        end else begin : g_in
            assign x_in = g_st[k-1].x_q;
            assign b_in = g_st[k-1].g_b.bs_q;
            assign c_in = g_st[k-1].c_q;
            assign v_in = g_st[k-1].v_q;
        end

        // x carries A's upper slices and the finished lower result slices
        always_comb begin
            sum = {1'b0, x_in[k*SEG +: SEG]}
                + {1'b0, b_in[SEG-1:0]}
                + {{SEG{1'b0}}, c_in};
            x_d = x_in;
            x_d[k*SEG +: SEG] = sum[SEG-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                x_q <= '0;
                c_q <= 1'b0;
            end else if (advance) begin
                v_q <= v_in;
                if (v_in) begin
                    x_q <= x_d;
                    c_q <= sum[SEG];
                end
            end
        end

        if (k < STAGES - 1) begin : g_b
            logic [BI-SEG-1:0] bs_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bs_q <= '0;
                end else if (advance && v_in) begin
                    bs_q <= b_in[BI-1:SEG];
                end
            end
        end

`ifdef PIPE_ADD_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance && v_in) begin
                    ovf_q <= (x_in[WIDTH-1] == b_in[SEG-1])
                          && (sum[SEG-1] != x_in[WIDTH-1]);
                end
            end
        end
`endif
    end

    assign result    = g_st[STAGES-1].x_q;
    assign carry     = g_st[STAGES-1].c_q;
    assign out_valid = g_st[STAGES-1].v_q;

`ifdef PIPE_ADD_OVF_EN
    assign overflow = g_st[STAGES-1].g_ovf.ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_add.sv
// tb_pipe_add: directed checks of pipe_add (16/4 main instance, 8/1 single-stage instance).
// Overflow expectations follow PIPE_ADD_OVF_EN.
module tb_pipe_add;

`ifdef PIPE_ADD_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] r1;
    logic [15:0] r2;
    logic        ci;
    logic        sub;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] result;
    logic        carry;
    logic        overflow;
    logic        out_valid;
    logic        out_ready;

    logic [7:0]  s_r1;
    logic [7:0]  s_r2;
    logic        s_ci;
    logic        s_sub;
    logic        s_iv;
    logic        s_ir;
    logic [7:0]  s_res;
    logic        s_c;
    logic        s_ov;
    logic        s_ovld;
    logic        s_ordy;

    int total;
    int bad;

    logic [15:0] seq_exp [8] = '{16'h0000, 16'h1112, 16'h2224, 16'h3336,
                                 16'h4448, 16'h555A, 16'h666C, 16'h777E};

    pipe_add #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r1        (r1),
        .r2        (r2),
        .ci        (ci),
        .sub       (sub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    pipe_add #(.WIDTH(8), .STAGES(1)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .r1        (s_r1),
        .r2        (s_r2),
        .ci        (s_ci),
        .sub       (s_sub),
        .in_valid  (s_iv),
        .in_ready  (s_ir),
        .result    (s_res),
        .carry     (s_c),
        .overflow  (s_ov),
        .out_valid (s_ovld),
        .out_ready (s_ordy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic op16(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic c, input logic s,
                        input logic [15:0] er, input logic ec,
                        input logic eo);
        int n;
        @(negedge clk);
        r1 = a;
        r2 = b;
        ci = c;
        sub = s;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd4);
        chk({tag, "_res"}, 32'(result), 32'(er));
        chk({tag, "_c"}, 32'(carry), 32'(ec));
        chk({tag, "_ov"}, 32'(overflow), 32'(eo));
    endtask

    initial begin
        int sent;
        int got;
        int stall;
        int lowc;
        int cyc;
        int stale;

        total = 0;
        bad = 0;
        rst_n = 1'b0;
        r1 = '0;
        r2 = '0;
        ci = 1'b0;
        sub = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        s_r1 = '0;
        s_r2 = '0;
        s_ci = 1'b0;
        s_sub = 1'b0;
        s_iv = 1'b0;
        s_ordy = 1'b1;

        #1;
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(result), 32'd0);
        chk("rst_c", 32'(carry), 32'd0);
        chk("rst_ov", 32'(overflow), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        op16("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("sub57", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op16("sub75", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        op16("ovfp", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF);
        op16("ovfn", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, OVF);
        op16("chain", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        op16("cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

        sent = 0;
        got = 0;
        stall = 0;
        lowc = 0;
        cyc = 0;
        while (got < 8 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            out_ready = (stall == 0);
            if (sent < 8) begin
                r1 = 16'(sent);
                r2 = 16'(sent) * 16'h1111;
                ci = 1'b0;
                sub = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!in_ready) lowc++;
            if (stall > 0) begin
                chk("stl_rdy", 32'(in_ready), 32'd0);
                chk("stl_vld", 32'(out_valid), 32'd1);
                chk("stl_res", 32'(result), 32'(seq_exp[got]));
                chk("stl_c", 32'(carry), 32'd0);
                stall--;
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk("seq_res", 32'(result), 32'(seq_exp[got]));
                chk("seq_c", 32'(carry), 32'd0);
                got++;
                if (got == 2) stall = 3;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("seq_cnt", 32'(got), 32'd8);
        chk("rdy_low", 32'(lowc), 32'd3);

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            r1 = 16'h1000 + 16'(i);
            r2 = 16'h0100;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", 32'(out_valid), 32'd0);
        chk("mrst_res", 32'(result), 32'd0);
        chk("mrst_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("mrst_stale", 32'(stale), 32'd0);
        op16("post", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

        @(negedge clk);
        s_r1 = 8'h80;
        s_r2 = 8'h80;
        s_ci = 1'b1;
        s_sub = 1'b0;
        s_iv = 1'b1;
        @(negedge clk);
        s_iv = 1'b0;
        chk("s1_vld", 32'(s_ovld), 32'd1);
        chk("s1_res", 32'(s_res), 32'h01);
        chk("s1_c", 32'(s_c), 32'd1);
        chk("s1_ov", 32'(s_ov), 32'(OVF));
        s_r1 = 8'h10;
        s_r2 = 8'h01;
        s_ci = 1'b0;
        s_sub = 1'b1;
        s_iv = 1'b1;
        @(negedge clk);
        s_iv = 1'b0;
        chk("s1b_vld", 32'(s_ovld), 32'd1);
        chk("s1b_res", 32'(s_res), 32'h0F);
        chk("s1b_c", 32'(s_c), 32'd1);
        @(negedge clk);
        chk("s1_idle", 32'(s_ovld), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_add.md
# pipe_add

Parametrised, pipelined add/subtract unit that generalises the team's 4-bit ripple-carry adder to WIDTH bits split across STAGES registered carry-chain segments, with a valid/ready handshake. It sits between operand-producing logic and any consumer needing a wide sum at full clock rate. Carry ripples within a segment and is registered between segments, so one operation enters per cycle and completes STAGES cycles later.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4: number of pipeline segments (1..WIDTH); segment width SEG = WIDTH/STAGES.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- r1  in  WIDTH  operand A.
- r2  in  WIDTH  operand B.
- ci  in  1  carry-in (borrow-in when sub=1).
- sub  in  1  0: A+B+ci; 1: A−B−ci.
- in_valid  in  1  operands valid this cycle.
- in_ready  out  1  unit accepts operands this cycle.
- result  out  WIDTH  sum/difference.
- carry  out  1  raw carry-out of MSB (sub=1: 1 = no borrow).
- overflow  out  1  signed overflow (see Configuration).
- out_valid  out  1  result/carry/overflow valid.
- out_ready  in  1  consumer accepts result this cycle.

## Operation
- Operand conditioning at entry: B' = sub ? ~r2 : r2; cin' = sub ? ~ci : ci. Result = A + B' + cin' mod 2^WIDTH; carry = bit WIDTH of that sum.
- Stage k (0..STAGES−1) adds bits [k·SEG+SEG−1 : k·SEG] of A and B' with the carry registered from stage k−1 (stage 0 uses cin'). Higher operand slices travel forward unmodified in skew registers; lower result slices travel forward in deskew registers.
- Each stage holds one valid bit. advance = !out_valid | out_ready. When advance=1 every stage shifts forward one position; when 0 all stages hold (global stall).
- in_ready = advance (combinational). Transfer in occurs when in_valid & in_ready; otherwise a bubble (valid=0) enters stage 0 on advance.
- Transfer out occurs when out_valid & out_ready.
- Results emerge strictly in acceptance order; no operation is dropped or duplicated.
- STAGES=1: single registered full-width adder, latency 1.

## Timing
- Reset (rst_n=0, asynchronous): all valid bits 0, all data/carry registers 0. Outputs: result=0, carry=0, overflow=0, out_valid=0; in_ready=1 (follows advance). Reset mid-operation discards all in-flight operations.
- Latency: operation accepted in cycle t appears with out_valid=1 in cycle t+STAGES when no stall intervenes; each stall cycle adds one.
- Throughput: one operation per cycle while out_ready=1.
- Simultaneous accept and deliver in one cycle allowed (full pipeline, out_ready=1).
- out_valid=1 & out_ready=0: result, carry, overflow held stable; in_ready=0.
- Wrap-around: result modulo 2^WIDTH; no saturation.

## Configuration
- PIPE_ADD_OVF_EN defined: overflow = (A[MSB] == B'[MSB]) & (result[MSB] != A[MSB]), computed in the final stage and registered alongside result.
- Undefined: overflow tied to 0; no overflow-tracking logic or MSB sign registers instantiated.

## Test plan
- WIDTH=16, STAGES=4: r1=0xFFFF, r2=0x0001, ci=0, sub=0 accepted at cycle t -> out_valid at t+4, result=0x0000, carry=1, overflow=0.
- sub=1: r1=0x0005, r2=0x0007, ci=0 -> result=0xFFFE, carry=0; r1=0x0007, r2=0x0005, ci=1 -> result=0x0001, carry=1.
- With PIPE_ADD_OVF_EN: 0x7FFF+0x0001 -> result=0x8000, overflow=1; 0x8000−0x0001 -> result=0x7FFF, overflow=1; without macro overflow stays 0.
- 8 back-to-back ops (r1=i, r2=i·0x1111), out_ready low for 3 cycles after the 2nd result -> in_ready low exactly those cycles, held outputs stable, all 8 results correct and in order.
- Pulse rst_n low for 1 cycle with 3 ops in flight -> out_valid=0, result=0 immediately; no stale results emerge afterwards; next op completes after 4 cycles.
- WIDTH=8, STAGES=1: 0x80+0x80, ci=1 -> next cycle result=0x01, carry=1.
